// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 holding SR/Cause/EPC/PRId with interrupt and exception request logic
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a_rd,
    input  logic [4:0]  a_wr,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        req
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd_q;
    logic [5:0]  ip;
    logic [4:0]  exc_q;
    logic [31:0] epc;
    logic        int_req;
    logic        exc_req;
    logic [31:0] sr;
    logic [31:0] cause;

    assign int_req = (|(hw_int & im)) & ie & ~exl;
    assign exc_req = (exc_code != 5'd0) & ~exl;
    assign req     = int_req | exc_req;
    assign sr      = {16'b0, im, 8'b0, exl, ie};
    assign cause   = {bd_q, 15'b0, ip, 3'b0, exc_q, 2'b0};
    assign epc_out = epc;

    // Register update: req captures the victim and drops any mtc0; eret clears EXL after an SR write
    always_ff @(posedge clk) begin
        if (!reset) begin
            im    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd_q  <= 1'b0;
            ip    <= '0;
            exc_q <= '0;
            epc   <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl   <= 1'b1;
                bd_q  <= bd;
                exc_q <= int_req ? 5'd0 : exc_code;
                epc   <= bd ? pc - 32'd4 : pc;
            end else begin
                if (we && a_wr == 5'd12) begin
                    im <= din[15:10];
                    ie <= din[0];
                end
                exl <= exl_clr ? 1'b0 : (we && a_wr == 5'd12) ? din[1] : exl;
                if (we && a_wr == 5'd14)
                    epc <= din;
            end
        end
    end

    // mfc0 read mux of current register contents
    always_comb begin
        dout = (a_rd == 5'd12) ? sr :
               (a_rd == 5'd13) ? cause :
               (a_rd == 5'd14) ? epc :
               (a_rd == 5'd15) ? PRID : 32'd0;
    end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the pipelined MIPS core. It holds SR, Cause, EPC and PRId, and it detects interrupts and exceptions presented by the M stage. On an exception or interrupt it captures the victim PC into EPC. It exposes EPC to next-PC selection so that `eret` can return, which makes it the writer of the EPC value the next-PC logic consumes.

## Interface
Parameters:
- PRID, 32'h2023_0007: constant value returned when PRId (reg 15) is read.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge clears all state.
- a_rd  input  5  mfc0 read register number.
- a_wr  input  5  mtc0 write register number.
- din  input  32  mtc0 write data.
- we  input  1  mtc0 write enable (M stage).
- pc  input  32  PC of the instruction currently in M.
- bd  input  1  M instruction sits in a branch/jump delay slot.
- exc_code  input  5  M-stage exception code; 0 = none.
- hw_int  input  6  external interrupt lines, level-sensitive.
- exl_clr  input  1  `eret` in M.
- dout  output  32  mfc0 read data (combinational).
- epc_out  output  32  current EPC register, fed to next-PC logic.
- req  output  1  flush pipeline and redirect fetch to handler 32'h0000_4180.

## Operation
Register fields:
- SR (12) contains IM[15:10], EXL[1] and IE[0]. All other bits read 0.
- Cause (13) contains BD[31], IP[15:10] and ExcCode[6:2]. All other bits read 0.
- EPC (14) is a full 32-bit register.
- PRId (15) is read-only and returns PRID.

Request logic (combinational):
- int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL.
- exc_req = (exc_code != 0) & !SR.EXL.
- req = int_req | exc_req.
- Interrupt has priority over an exception in the same cycle.

State update at each posedge, with reset=1:
- Cause.IP <= hw_int every cycle, unconditionally.
- If req:
  - SR.EXL <= 1.
  - Cause.BD <= bd.
  - Cause.ExcCode <= int_req ? 0 : exc_code.
  - EPC <= bd ? pc−4 : pc. The subtraction is 32-bit modulo and has no alignment masking.
  - Any mtc0 in the same cycle is discarded.
- Else if we:
  - a_wr=12: IM, EXL and IE take din[15:10], din[1] and din[0].
  - a_wr=14: EPC <= din.
  - Writes to 13, 15 and any other number are ignored.
- exl_clr with req=0 forces SR.EXL <= 0. This applies after any same-cycle mtc0 to SR, so exl_clr wins on the EXL bit only.
- exl_clr with req=1 is ignored, and EXL is set.

Read logic:
- dout returns the current register contents for 12/13/14/15 and 0 for any other a_rd.
- dout does not forward a same-cycle write.

Reset (reset=0 at a posedge):
- SR, Cause and EPC are cleared to 0.
- With inputs idle, req=0, dout=0 for reads of 12/13/14, and epc_out=0.
- Reset beats every concurrent req, we and exl_clr.

## Timing
- req and dout are combinational in the same cycle as their inputs. There are no registered outputs besides state.
- Register effects of req, mtc0 and eret are visible at the next cycle: one-cycle latency to dout and epc_out.
- An mtc0 to EPC followed by `eret` in the immediately next M cycle sees the new EPC on epc_out. Same-cycle write-then-read needs no support, because eret and mtc0 cannot share M.
- Once req fires, EXL blocks further req until exl_clr or an mtc0 clears EXL. This gives no nesting.
- hw_int is sampled into IP each cycle. A line dropping before being unmasked never triggers req.

## Test plan
- Reset: hold reset=0 two cycles with we=1, din=32'hFFFF_FFFF, a_wr=12 -> SR/Cause/EPC read 0, req=0.
- Interrupt: mtc0 SR=32'h0000_0401 (IM[10], IE), then hw_int=6'b000001, pc=32'h0000_3010, bd=0 -> req=1 that cycle. Next cycle: EPC=32'h0000_3010, Cause=32'h0000_0400, SR.EXL=1, req=0.
- Delay-slot exception: exc_code=5'd12, bd=1, pc=32'h0000_3024 -> req=1. Next cycle: EPC=32'h0000_3020, Cause=32'h8000_0030.
- Priority and collision: int_req and exc_code=5'd4 together with we=1, a_wr=14, din=32'h1234 -> ExcCode=0, EPC=pc, and the write is dropped.
- eret: with EXL=1, exl_clr=1 and simultaneous mtc0 SR=32'h0000_0403 -> SR reads 32'h0000_0401 next cycle, and a pending masked interrupt raises req that following cycle.
- Reads: a_rd=15 -> PRID; a_rd=7 -> 0; mtc0 to 13 leaves Cause unchanged.
